conv_window_gen: RTL

//  Raster-stream window generator that feeds the Laplacian multiply stage (ConvolutionStage1).

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_line_buf.sv | 20 ++
 rtl/conv_window_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared pixel type, window/column structs and default frame size for conv_window_gen.
package conv_pkg;
    localparam int PIX_W     = 4;
    localparam int IMG_W_DEF = 8;
    localparam int IMG_H_DEF = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t n;
        pix_t m;
        pix_t s;
    } col_t;

    typedef struct packed {
        pix_t n;
        pix_t w;
        pix_t c;
        pix_t e;
        pix_t s;
    } win_t;
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one image line of pixels, combinational read and clocked write, so a same-beat
// read returns the old contents (read-before-write).
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pix_t                     wdata,
    output pix_t                     rdata
);
    pix_t r_mem [DEPTH];

    always_ff @(posedge clk)
        if (we) r_mem[addr] <= wdata;

    assign rdata = r_mem[addr];
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster-stream cross window (N,W,C,E,S) generator for the Laplacian multiply stage.
// Define WIN_COORD_EN to add win_row/win_col centre-coordinate outputs.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  pix_t                     pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output logic                     win_valid,
    output pix_t                     win_n,
    output pix_t                     win_w,
    output pix_t                     win_c,
    output pix_t                     win_e,
`ifdef WIN_COORD_EN
    output pix_t                     win_s,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
`else
    output pix_t                     win_s
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] r_col, w_col;
    logic [RW-1:0] r_row, w_row;
    logic          w_last_col, w_fire;
    pix_t          w_lb0_rd, w_lb1_rd;
    col_t          r_c1;
    pix_t          r_m2;
    win_t          r_win;
    logic          r_valid;
`ifdef WIN_COORD_EN
    logic [RW-1:0] r_wrow;
    logic [CW-1:0] r_wcol;
`endif

    // sof forces this beat to (0,0) regardless of where the counters were
    always_comb begin
        w_col      = sof ? '0 : r_col;
        w_row      = sof ? '0 : r_row;
        w_last_col = w_col == CW'(IMG_W - 1);
        w_fire     = (w_row >= RW'(2)) && (w_col >= CW'(2));
    end

    conv_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (w_col),
        .wdata (pix_in),
        .rdata (w_lb1_rd)
    );

    conv_line_buf #(.DEPTH(IMG_W)) u_lb0 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (w_col),
        .wdata (w_lb1_rd),
        .rdata (w_lb0_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_c1    <= '0;
            r_m2    <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
`ifdef WIN_COORD_EN
            r_wrow  <= '0;
            r_wcol  <= '0;
`endif
        end else if (pix_valid) begin
            r_col   <= w_last_col ? '0 : w_col + CW'(1);
            r_row   <= !w_last_col ? w_row : (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
            r_c1    <= '{n: w_lb0_rd, m: w_lb1_rd, s: pix_in};
            r_m2    <= r_c1.m;
            r_valid <= w_fire;
            if (w_fire) begin
                r_win  <= '{n: r_c1.n, w: r_m2, c: r_c1.m, e: w_lb1_rd, s: r_c1.s};
`ifdef WIN_COORD_EN
                r_wrow <= w_row - RW'(1);
                r_wcol <= w_col - CW'(1);
`endif
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign win_valid = r_valid;
    assign win_n     = r_win.n;
    assign win_w     = r_win.w;
    assign win_c     = r_win.c;
    assign win_e     = r_win.e;
    assign win_s     = r_win.s;
`ifdef WIN_COORD_EN
    assign win_row   = r_wrow;
    assign win_col   = r_wcol;
`endif
endmodule
